// File: rtl/rgb_to_gray_pp_if.sv
// AXI4-Stream video link (tdata/tvalid/tready/tuser/tlast).
// master drives the beat, slave drives tready.
interface rgb_to_gray_pp_if #(
  parameter int W = 8
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tuser;
  logic         tlast;

  modport master (
    output tdata, tvalid, tuser, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tuser, tlast,
    output tready
  );
endinterface

// File: rtl/rgb_to_gray_pp.sv
// RGB->gray, PPC pixels/beat, 3-stage pipeline with backpressure.
// Define RGB2GRAY_ROUND_EN for round-half-up instead of truncation.
module rgb_to_gray_pp #(
  parameter int DATA_WIDTH = 8,
  parameter int PPC        = 4,
  parameter int COEF_W     = 9,
  parameter int COEF_FRAC  = 8,
  parameter int K_R        = 77,
  parameter int K_G        = 150,
  parameter int K_B        = 29
) (
  input  logic             aclk,
  input  logic             areset,
  rgb_to_gray_pp_if.slave  s_axis_rgb,
  rgb_to_gray_pp_if.master m_axis_gray
);

  localparam int DW = DATA_WIDTH;
  localparam int PW = DW + COEF_W;
  localparam int SW = PW + 2;

  localparam logic [COEF_W-1:0] KR = COEF_W'(K_R);
  localparam logic [COEF_W-1:0] KG = COEF_W'(K_G);
  localparam logic [COEF_W-1:0] KB = COEF_W'(K_B);

  localparam logic [SW-1:0] YMAX =
    {{(SW-DW){1'b0}}, {DW{1'b1}}};

`ifdef RGB2GRAY_ROUND_EN
  localparam logic [SW-1:0] RND =
    SW'(1) << (COEF_FRAC - 1);
`else
  localparam logic [SW-1:0] RND = '0;
`endif

  logic v1, v2, v3;
  logic u1, u2, u3;
  logic l1, l2, l3;
  logic en;

  logic [PW-1:0] pr [PPC];
  logic [PW-1:0] pg [PPC];
  logic [PW-1:0] pb [PPC];
  logic [SW-1:0] sum [PPC];

  logic [DW*PPC-1:0] gray_d;
  logic [DW*PPC-1:0] gray_q;

  // Whole pipe advances together; bubbles collapse only at the output.
  assign en = ~v3 | m_axis_gray.tready;

  assign s_axis_rgb.tready  = en;
  assign m_axis_gray.tvalid = v3;
  assign m_axis_gray.tuser  = u3;
  assign m_axis_gray.tlast  = l3;
  assign m_axis_gray.tdata  = gray_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      v1 <= 1'b0;
      v2 <= 1'b0;
      v3 <= 1'b0;
      u1 <= 1'b0;
      u2 <= 1'b0;
      u3 <= 1'b0;
      l1 <= 1'b0;
      l2 <= 1'b0;
      l3 <= 1'b0;
      gray_q <= '0;
    end else if (en) begin
      v1 <= s_axis_rgb.tvalid;
      v2 <= v1;
      v3 <= v2;
      if (s_axis_rgb.tvalid) begin
        u1 <= s_axis_rgb.tuser;
        l1 <= s_axis_rgb.tlast;
      end
      if (v1) begin
        u2 <= u1;
        l2 <= l1;
      end
      if (v2) begin
        u3 <= u2;
        l3 <= l2;
        gray_q <= gray_d;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (en && s_axis_rgb.tvalid) begin
      for (int p = 0; p < PPC; p++) begin
        pr[p] <= PW'(KR) *
          PW'(s_axis_rgb.tdata[3*DW*p + 2*DW +: DW]);
        pg[p] <= PW'(KG) *
          PW'(s_axis_rgb.tdata[3*DW*p +: DW]);
        pb[p] <= PW'(KB) *
          PW'(s_axis_rgb.tdata[3*DW*p + DW +: DW]);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (en && v1) begin
      for (int p = 0; p < PPC; p++) begin
        sum[p] <= SW'(pr[p]) + SW'(pg[p]) +
          SW'(pb[p]) + RND;
      end
    end
  end

  always_comb begin
    logic [SW-1:0] y;
    y      = '0;
    gray_d = '0;
    for (int p = 0; p < PPC; p++) begin
      y = sum[p] >> COEF_FRAC;
      if (y > YMAX) begin
        gray_d[DW*p +: DW] = {DW{1'b1}};
      end else begin
        gray_d[DW*p +: DW] = y[DW-1:0];
      end
    end
  end

endmodule

// File: tb/tb_rgb_to_gray_pp.sv
// Bench for rgb_to_gray_pp: default 4-ppc core plus a 1-ppc
// K=128 core fed with pixel 0 of the same stream.
module tb_rgb_to_gray_pp;

  logic aclk = 1'b0;
  logic areset = 1'b1;

  always #5 aclk = ~aclk;

  rgb_to_gray_pp_if #(.W(96)) s0 ();
  rgb_to_gray_pp_if #(.W(32)) m0 ();
  rgb_to_gray_pp_if #(.W(24)) s1 ();
  rgb_to_gray_pp_if #(.W(8))  m1 ();

  rgb_to_gray_pp u0 (
    .aclk        (aclk),
    .areset      (areset),
    .s_axis_rgb  (s0),
    .m_axis_gray (m0)
  );

  rgb_to_gray_pp #(
    .PPC (1),
    .K_R (128),
    .K_G (128),
    .K_B (128)
  ) u1 (
    .aclk        (aclk),
    .areset      (areset),
    .s_axis_rgb  (s1),
    .m_axis_gray (m1)
  );

`ifdef RGB2GRAY_ROUND_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif

  typedef struct packed {
    logic [31:0] g0;
    logic [7:0]  g1;
    logic        u;
    logic        l;
  } exp_t;

  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int pushed = 0;
  int popped = 0;
  int discarded = 0;
  int stall_cycles = 0;
  int stall_left = 0;
  int n;
  logic rnd_rdy = 1'b0;
  logic force_rdy = 1'b1;
  logic acc, vld_seen, have_prev;
  logic [31:0] prev_d;
  logic prev_u, prev_l;

  function automatic logic [7:0] gray(
    input int kr, input int kg, input int kb,
    input logic [23:0] px
  );
    int s;
    s = kr * int'(px[23:16]) + kg * int'(px[7:0]) +
        kb * int'(px[15:8]) + RND;
    s = s / 256;
    return (s > 255) ? 8'hFF : s[7:0];
  endfunction

  function automatic exp_t model(
    input logic [95:0] d, input logic u, input logic l
  );
    exp_t e;
    for (int p = 0; p < 4; p++)
      e.g0[8*p +: 8] = gray(77, 150, 29, d[24*p +: 24]);
    e.g1 = gray(128, 128, 128, d[23:0]);
    e.u  = u;
    e.l  = l;
    return e;
  endfunction

  task automatic chk(
    input string tag, input logic [63:0] got,
    input logic [63:0] exp
  );
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    exp_t e;
    logic rdy;
    @(negedge aclk);
    acc = s0.tvalid && s0.tready && !areset;
    vld_seen = m0.tvalid;
    if (areset) begin
      discarded += q.size();
      q.delete();
      have_prev = 1'b0;
    end else begin
      if (m0.tvalid && m0.tready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          e = q.pop_front();
          chk("gray_ppc4", m0.tdata, e.g0);
          chk("gray_k128", m1.tdata, e.g1);
          chk("k128_tvalid", m1.tvalid, 1);
          chk("tuser", m0.tuser, e.u);
          chk("tlast", m0.tlast, e.l);
          popped++;
        end
      end
      if (m0.tvalid && !m0.tready) begin
        stall_cycles++;
        chk("stall_s_tready", s0.tready, 0);
        if (have_prev) begin
          chk("stall_tdata", m0.tdata, prev_d);
          chk("stall_tuser", m0.tuser, prev_u);
          chk("stall_tlast", m0.tlast, prev_l);
        end
        have_prev = 1'b1;
        prev_d = m0.tdata;
        prev_u = m0.tuser;
        prev_l = m0.tlast;
      end else begin
        have_prev = 1'b0;
      end
      if (acc) begin
        q.push_back(model(s0.tdata, s0.tuser, s0.tlast));
        pushed++;
      end
    end
    @(posedge aclk);
    #1;
    if (stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
    end else begin
      rdy = rnd_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end
    m0.tready = rdy;
    m1.tready = rdy;
  endtask

  task automatic send(
    input logic [95:0] d, input logic u, input logic l
  );
    s0.tdata = d;
    s0.tuser = u;
    s0.tlast = l;
    s0.tvalid = 1'b1;
    s1.tdata = d[23:0];
    s1.tuser = u;
    s1.tlast = l;
    s1.tvalid = 1'b1;
    for (int i = 0; i <= 200; i++) begin
      tick();
      if (acc) break;
      if (i == 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout got no tready exp accept");
        $fatal(1, "input handshake timed out");
      end
    end
    s0.tvalid = 1'b0;
    s1.tvalid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (q.size() == 0) break;
      tick();
    end
    chk("drain_empty", q.size(), 0);
  endtask

  function automatic logic [95:0] rnd96();
    return {$urandom, $urandom, $urandom};
  endfunction

  initial begin
    s0.tdata = '0;
    s0.tvalid = 1'b0;
    s0.tuser = 1'b0;
    s0.tlast = 1'b0;
    s1.tdata = '0;
    s1.tvalid = 1'b0;
    s1.tuser = 1'b0;
    s1.tlast = 1'b0;
    m0.tready = 1'b1;
    m1.tready = 1'b1;

    repeat (2) tick();
    chk("rst_tvalid", m0.tvalid, 0);
    chk("rst_tdata", m0.tdata, 0);
    chk("rst_tuser", m0.tuser, 0);
    chk("rst_tlast", m0.tlast, 0);
    chk("rst_k128_tdata", m1.tdata, 0);
    chk("rst_s_tready", s0.tready, 1);
    areset = 1'b0;

    // white on every pixel, measure latency
    send({4{24'hFFFFFF}}, 1'b0, 1'b0);
    for (n = 1; n <= 10; n++) begin
      tick();
      if (vld_seen) break;
    end
    chk("latency", n, 3);

    // single primaries, then mid gray on the K=128 core
    send({24'h000000, 24'h00FF00, 24'h0000FF, 24'hFF0000},
         1'b0, 1'b0);
    send({72'h0, 24'h282828}, 1'b0, 1'b0);
    drain();

    // 16-beat line with a 5-clock sink stall at beat 6
    for (int b = 0; b < 16; b++) begin
      if (b == 6) stall_left = 5;
      send(rnd96(), b == 0, b == 15);
    end
    drain();
    chk("stall_observed", stall_cycles >= 4, 1);

    // fill the pipe against a stalled sink, then reset
    force_rdy = 1'b0;
    tick();
    for (int b = 0; b < 3; b++) send(rnd96(), 1'b0, 1'b1);
    chk("pipe_full_tvalid", m0.tvalid, 1);
    chk("pipe_full_s_tready", s0.tready, 0);
    areset = 1'b1;
    tick();
    areset = 1'b0;
    chk("mid_rst_tvalid", m0.tvalid, 0);
    chk("mid_rst_tdata", m0.tdata, 0);
    force_rdy = 1'b1;
    tick();
    send({4{24'h123456}}, 1'b1, 1'b0);
    send({4{24'hABCDEF}}, 1'b0, 1'b1);
    drain();

    // random valid and ready
    rnd_rdy = 1'b1;
    for (int b = 0; b < 400; b++) begin
      repeat ($urandom_range(0, 1)) tick();
      send(rnd96(), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    force_rdy = 1'b1;
    tick();
    drain();

    chk("beat_count", popped, pushed - discarded);
    chk("discarded_beats", discarded, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
